// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: BCD digit type and per-digit limits,
// used by the time counter, alarm register and key register.
package alarm_clock_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t MIN_LS_MAX      = 4'd9;
  localparam digit_t MIN_MS_MAX      = 4'd5;
  localparam digit_t HR_LS_MAX       = 4'd9;
  localparam digit_t HR_MS_MAX       = 4'd2;
  localparam digit_t HR_LS_MAX_AT_20 = 4'd3;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: parallel load, increment with wrap at a runtime maximum,
// and a carry that fires when an increment wraps the digit.
module bcd_digit_counter
  import alarm_clock_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  digit_t max,
  input  logic   inc,
  input  logic   load,
  input  digit_t load_val,
  output digit_t q,
  output logic   carry_out
);

  logic at_max;

  // >= rather than == so an out-of-range loaded digit still wraps and carries
  assign at_max    = (q >= max);
  assign carry_out = inc && at_max && !load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= at_max ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/clock_counter.sv
// HH:MM BCD time-of-day counter with one-minute ticks and parallel load.
// Optional load range check enabled by defining CLOCK_COUNTER_LOAD_CHECK_EN.
module clock_counter
  import alarm_clock_pkg::*;
#(
  parameter digit_t MAX_HR_MS       = 4'd2,
  parameter digit_t MAX_HR_LS_AT_MS = 4'd3
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   one_minute,
  input  logic   load_new_c,
  input  digit_t new_current_time_ms_hr,
  input  digit_t new_current_time_ls_hr,
  input  digit_t new_current_time_ms_min,
  input  digit_t new_current_time_ls_min,
  output digit_t current_time_ms_hr,
  output digit_t current_time_ls_hr,
  output digit_t current_time_ms_min,
  output digit_t current_time_ls_min,
  output logic   day_rollover,
  output logic   load_error
);

  logic load_valid;
  logic load_ok;
  logic tick;
  logic hour_wrap;
  logic hr_load;
  logic c_ls_min, c_ms_min, c_ls_hr, c_ms_hr;

`ifdef CLOCK_COUNTER_LOAD_CHECK_EN
  always_comb begin
    load_valid = (new_current_time_ms_hr  <= HR_MS_MAX)
              && (new_current_time_ls_hr  <= HR_LS_MAX)
              && (new_current_time_ms_min <= MIN_MS_MAX)
              && (new_current_time_ls_min <= MIN_LS_MAX)
              && !((new_current_time_ms_hr == HR_MS_MAX)
                   && (new_current_time_ls_hr > HR_LS_MAX_AT_20));
  end
`else
  assign load_valid = 1'b1;
`endif

  // A load strobe always swallows a simultaneous tick, even when rejected
  assign load_ok   = load_new_c && load_valid;
  assign tick      = one_minute && !load_new_c;
  assign hour_wrap = c_ms_min && (current_time_ms_hr >= MAX_HR_MS)
                              && (current_time_ls_hr >= MAX_HR_LS_AT_MS);
  assign hr_load   = load_ok || hour_wrap;

  bcd_digit_counter u_ls_min (
    .clk(clk), .reset(reset), .max(MIN_LS_MAX), .inc(tick), .load(load_ok),
    .load_val(new_current_time_ls_min), .q(current_time_ls_min), .carry_out(c_ls_min)
  );

  bcd_digit_counter u_ms_min (
    .clk(clk), .reset(reset), .max(MIN_MS_MAX), .inc(c_ls_min), .load(load_ok),
    .load_val(new_current_time_ms_min), .q(current_time_ms_min), .carry_out(c_ms_min)
  );

  // Hour digits reuse the load path to force 00 on the end-of-day wrap
  bcd_digit_counter u_ls_hr (
    .clk(clk), .reset(reset), .max(HR_LS_MAX), .inc(c_ms_min && !hour_wrap),
    .load(hr_load), .load_val(load_ok ? new_current_time_ls_hr : 4'd0),
    .q(current_time_ls_hr), .carry_out(c_ls_hr)
  );

  bcd_digit_counter u_ms_hr (
    .clk(clk), .reset(reset), .max(MAX_HR_MS), .inc(c_ls_hr),
    .load(hr_load), .load_val(load_ok ? new_current_time_ms_hr : 4'd0),
    .q(current_time_ms_hr), .carry_out(c_ms_hr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      day_rollover <= 1'b0;
      load_error   <= 1'b0;
    end else begin
      day_rollover <= hour_wrap || c_ms_hr;
      load_error   <= load_new_c && !load_valid;
    end
  end

endmodule

// File: tb/tb_clock_counter.sv
// Self-checking bench for clock_counter; reference model keeps time as
// minutes since midnight. Define CLOCK_COUNTER_LOAD_CHECK_EN for the checked build.
module tb_clock_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       one_minute = 1'b0;
  logic       load_new_c = 1'b0;
  logic [3:0] n_ms_hr = '0, n_ls_hr = '0, n_ms_min = '0, n_ls_min = '0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       day_rollover, load_error;
  logic [15:0] cur;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign cur = {ms_hr, ls_hr, ms_min, ls_min};

  always #5 clk = ~clk;

  clock_counter dut (
    .clk(clk), .reset(reset), .one_minute(one_minute), .load_new_c(load_new_c),
    .new_current_time_ms_hr(n_ms_hr), .new_current_time_ls_hr(n_ls_hr),
    .new_current_time_ms_min(n_ms_min), .new_current_time_ls_min(n_ls_min),
    .current_time_ms_hr(ms_hr), .current_time_ls_hr(ls_hr),
    .current_time_ms_min(ms_min), .current_time_ls_min(ls_min),
    .day_rollover(day_rollover), .load_error(load_error)
  );

  // Model: minutes since midnight -> packed BCD HHMM
  function automatic logic [15:0] to_bcd(input int m);
    int h, mi;
    h  = m / 60;
    mi = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  function automatic int to_min(input logic [15:0] t);
    return (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  function automatic bit is_valid(input logic [15:0] t);
    return (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9) && (t[11:8] <= 4'd9)
        && ((int'(t[15:12]) * 10 + int'(t[11:8])) <= 23);
  endfunction

  // Drive strobes for one rising edge, then sample 1 time unit after it
  task automatic cycle(input logic ld, input logic tk, input logic [15:0] val);
    load_new_c = ld;
    one_minute = tk;
    {n_ms_hr, n_ls_hr, n_ms_min, n_ls_min} = val;
    @(posedge clk);
    #1;
    load_new_c = 1'b0;
    one_minute = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total_cnt++;
    if (cur !== 16'h0000 || day_rollover !== 1'b0 || load_error !== 1'b0)
      $display("FAIL reset_initial: got %h/%b/%b expected 0000/0/0", cur, day_rollover, load_error);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 16'h1233);
    cycle(1'b0, 1'b1, 16'h0000);
    total_cnt++;
    if (cur !== 16'h1234) $display("FAIL reset_pre_count: got %h expected 1234", cur);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if (cur !== 16'h0000) $display("FAIL reset_async: got %h expected 0000", cur);
    else pass_cnt++;
    total_cnt++;
    if (day_rollover !== 1'b0) $display("FAIL reset_rollover: got %b expected 0", day_rollover);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_carry_chain;
    logic [15:0] starts [3] = '{16'h0959, 16'h1959, 16'h0009};
    logic [15:0] exps   [3] = '{16'h1000, 16'h2000, 16'h0010};
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, starts[i]);
      cycle(1'b0, 1'b1, 16'h0000);
      total_cnt++;
      if (cur !== exps[i]) $display("FAIL carry_%h: got %h expected %h", starts[i], cur, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_day_wrap;
    cycle(1'b1, 1'b0, 16'h2359);
    total_cnt++;
    if (day_rollover !== 1'b0) $display("FAIL wrap_pre_pulse: got %b expected 0", day_rollover);
    else pass_cnt++;
    cycle(1'b0, 1'b1, 16'h0000);
    total_cnt++;
    if (cur !== 16'h0000 || day_rollover !== 1'b1)
      $display("FAIL wrap_2359: got %h/%b expected 0000/1", cur, day_rollover);
    else pass_cnt++;
    cycle(1'b0, 1'b1, 16'h0000);
    total_cnt++;
    if (cur !== 16'h0001 || day_rollover !== 1'b0)
      $display("FAIL wrap_next: got %h/%b expected 0001/0", cur, day_rollover);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    cycle(1'b1, 1'b0, 16'h0500);
    cycle(1'b1, 1'b1, 16'h1111);
    total_cnt++;
    if (cur !== 16'h1111) $display("FAIL simultaneous: got %h expected 1111", cur);
    else pass_cnt++;
  endtask

  task automatic test_full_day_sweep;
    int m = 0;
    int rolls = 0;
    int bad = 0;
    cycle(1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 1440; i++) begin
      cycle(1'b0, 1'b1, 16'h0000);
      m = (m + 1) % 1440;
      if (day_rollover === 1'b1) rolls++;
      if (!is_valid(cur)) bad++;
      total_cnt++;
      if (cur !== to_bcd(m)) $display("FAIL sweep_step%0d: got %h expected %h", i, cur, to_bcd(m));
      else pass_cnt++;
    end
    total_cnt++;
    if (rolls !== 1) $display("FAIL sweep_rollovers: got %0d expected 1", rolls);
    else pass_cnt++;
    total_cnt++;
    if (bad !== 0) $display("FAIL sweep_range: got %0d out-of-range states expected 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_random;
    int m;
    logic [15:0] val;
    bit ld, tk, exp_roll, exp_err;
    cycle(1'b1, 1'b0, 16'h0000);
    m = 0;
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      tk = ($urandom_range(0, 1) == 1);
`ifdef CLOCK_COUNTER_LOAD_CHECK_EN
      if ($urandom_range(0, 1) == 1) val = 16'($urandom);
      else val = to_bcd(int'($urandom_range(0, 1439)));
`else
      val = to_bcd(int'($urandom_range(0, 1439)));
`endif
      exp_roll = 1'b0;
      exp_err  = 1'b0;
      if (ld) begin
        if (is_valid(val)) m = to_min(val);
        else exp_err = 1'b1;
      end else if (tk) begin
        exp_roll = (m == 1439);
        m = (m + 1) % 1440;
      end
      cycle(ld, tk, val);
      total_cnt++;
      if (cur !== to_bcd(m) || day_rollover !== exp_roll || load_error !== exp_err)
        $display("FAIL random_step%0d: got %h/%b/%b expected %h/%b/%b",
                 i, cur, day_rollover, load_error, to_bcd(m), exp_roll, exp_err);
      else pass_cnt++;
    end
  endtask

`ifdef CLOCK_COUNTER_LOAD_CHECK_EN
  task automatic test_load_check;
    cycle(1'b1, 1'b0, 16'h0500);
    cycle(1'b1, 1'b1, 16'h2400);
    total_cnt++;
    if (cur !== 16'h0500 || load_error !== 1'b1)
      $display("FAIL check_2400: got %h/%b expected 0500/1", cur, load_error);
    else pass_cnt++;
    cycle(1'b0, 1'b0, 16'h0000);
    total_cnt++;
    if (load_error !== 1'b0) $display("FAIL check_err_pulse: got %b expected 0", load_error);
    else pass_cnt++;
    cycle(1'b1, 1'b0, 16'h1260);
    total_cnt++;
    if (cur !== 16'h0500 || load_error !== 1'b1)
      $display("FAIL check_1260: got %h/%b expected 0500/1", cur, load_error);
    else pass_cnt++;
    cycle(1'b1, 1'b0, 16'h2359);
    total_cnt++;
    if (cur !== 16'h2359 || load_error !== 1'b0)
      $display("FAIL check_2359: got %h/%b expected 2359/0", cur, load_error);
    else pass_cnt++;
  endtask
`else
  task automatic test_load_verbatim;
    cycle(1'b1, 1'b0, 16'h126B);
    total_cnt++;
    if (cur !== 16'h126B || load_error !== 1'b0)
      $display("FAIL verbatim_126B: got %h/%b expected 126b/0", cur, load_error);
    else pass_cnt++;
    cycle(1'b0, 1'b1, 16'h0000);
    total_cnt++;
    if (cur !== 16'h1300) $display("FAIL verbatim_tick: got %h expected 1300", cur);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_carry_chain();
    test_day_wrap();
    test_simultaneous();
    test_full_day_sweep();
`ifdef CLOCK_COUNTER_LOAD_CHECK_EN
    test_load_check();
`else
    test_load_verbatim();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clock_counter.md
# clock_counter

Time-of-day counter for the alarm clock. Holds current time as four BCD digits (HH:MM, 24-hour, 00:00–23:59), advances one minute per `one_minute` strobe, and accepts a parallel load of a keypad-entered time. Sits directly upstream of the display stage: each digit output feeds the `current_time` input of a per-digit LCD driver and the alarm-compare logic.

## Interface
Parameters:
- `MAX_HR_MS`, 2: maximum tens-of-hours digit.
- `MAX_HR_LS_AT_MS`, 3: maximum units-of-hours digit when the tens digit equals `MAX_HR_MS`.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `one_minute` input 1: single-cycle strobe; advance time by one minute.
- `load_new_c` input 1: single-cycle strobe; load `new_current_time_*`.
- `new_current_time_ms_hr` input 4: load value, tens of hours.
- `new_current_time_ls_hr` input 4: load value, units of hours.
- `new_current_time_ms_min` input 4: load value, tens of minutes.
- `new_current_time_ls_min` input 4: load value, units of minutes.
- `current_time_ms_hr` output 4: tens of hours, BCD.
- `current_time_ls_hr` output 4: units of hours, BCD.
- `current_time_ms_min` output 4: tens of minutes, BCD.
- `current_time_ls_min` output 4: units of minutes, BCD.
- `day_rollover` output 1: one-cycle pulse on the 23:59 → 00:00 wrap.
- `load_error` output 1: one-cycle pulse on a rejected load. Present only with `CLOCK_COUNTER_LOAD_CHECK_EN`; otherwise tied to 0.

## Operation
- Reset (`reset` low, asynchronous): all four digits = 0 (00:00); `day_rollover` = 0; `load_error` = 0.
- Priority per edge:
  1. `load_new_c`.
  2. `one_minute`.
  3. Hold.
- If `load_new_c` and `one_minute` are both high on the same edge, the load wins and the tick is dropped. The loaded value is not incremented.
- Increment chain, carry-propagate within one cycle:
  - `ls_min`: 0–9. On 9 it goes to 0 and carries.
  - `ms_min`: 0–5. On 5 with carry in, it goes to 0 and carries.
  - Hours: if `ms_hr` = `MAX_HR_MS` and `ls_hr` = `MAX_HR_LS_AT_MS` and a carry arrives, hours go to 00 and `day_rollover` pulses.
  - Otherwise `ls_hr` goes 0–9. On 9 it goes to 0 and `ms_hr` increments.
- Examples: 09:59 → 10:00; 19:59 → 20:00; 23:59 → 00:00 with `day_rollover` = 1.
- All digit arithmetic is 4-bit unsigned. No digit ever holds a value above its range after an increment from a valid state.
- Load without the check: all four values are copied verbatim. An out-of-range digit (e.g. `ls_min` = 4'hB) is stored as-is, and the downstream display shows its error glyph. A subsequent increment from an invalid digit treats any `ls_min` ≥ 9 as 9 (wrap and carry), and likewise for the other digits at their maximum.
- `day_rollover` and `load_error` are high for exactly one cycle after the causing edge, then return to 0.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Latency: outputs reflect a tick or load on the first rising `clk` edge at which the strobe is sampled high (1 cycle).
- `one_minute` held high for N cycles advances N minutes. Upstream guarantees single-cycle pulses.
- Reset asserted mid-operation overrides any pending strobe immediately. Release is synchronised by the system reset tree; the first edge after release may be a tick.

## Configuration
- `CLOCK_COUNTER_LOAD_CHECK_EN` defined: a load is accepted only if all of the following hold:
  - `ms_hr` ≤ 2;
  - `ls_hr` ≤ 9, and ≤ 3 when `ms_hr` = 2;
  - `ms_min` ≤ 5;
  - `ls_min` ≤ 9.
- A rejected load leaves all digits unchanged, pulses `load_error` one cycle, and still suppresses a simultaneous `one_minute`.
- Not defined: loads are unchecked and `load_error` = 0 constantly.

## Structure
- Shared package `alarm_clock_pkg`: digit limit constants (`MIN_LS_MAX` = 9, `MIN_MS_MAX` = 5, `HR_LS_MAX` = 9, `HR_MS_MAX` = 2, `HR_LS_MAX_AT_20` = 3) and the 4-bit BCD digit type. These are shared with the alarm register and the key register.
- One sub-module: `bcd_digit_counter`. It is a single digit with `max` input, `inc`, `load`, `load_val`, `q`, and `carry_out`. It is instantiated four times; the hours wrap is handled in the top.

## Test plan
- Reset: assert `reset` = 0 mid-count at 12:34 → all digits 0 asynchronously (before the next edge); `day_rollover` = 0.
- Carry chain: load 09:59, one tick → 10:00. Load 19:59, tick → 20:00. Load 00:09, tick → 00:10.
- Day wrap: load 23:59, tick → 00:00 with `day_rollover` = 1 for exactly one cycle; the next tick → 00:01 with `day_rollover` = 0.
- Simultaneous strobes: at 05:00, assert `load_new_c` (value 11:11) and `one_minute` on the same edge → 11:11, not 11:12.
- Full-day sweep: 1440 ticks from 00:00 → back to 00:00, exactly one `day_rollover`, every intermediate digit in range.
- With `CLOCK_COUNTER_LOAD_CHECK_EN`:
  - load 24:00 → time unchanged, `load_error` pulses once;
  - load 12:60 → rejected;
  - load 23:59 → accepted, `load_error` = 0.
- Without the macro: load 12:6B → outputs 1, 2, 6, 4'hB verbatim.
